tcm_image_loader: RTL and testbench
===================================

// Module: tcm_image_loader
// PURPOSE
//  Streams a program image byte-by-byte (from UART/SPI boot path) into the core TCM.
//  Assembles bytes into DATA_W words with selectable byte order and writes them sequentially
//  from a base word address. Replaces bench-side image preload with an in-system loader ahead of the TCM port.
// PARAMETERS
//  DATA_W  32     memory word width in bits; must be a multiple of 8
//  ADDR_W  14     word-address width (TCM depth = 2**ADDR_W words, 16384 default)
//  LEN_W   15     width of length field (max image = 2**LEN_W-1 words)
// PORTS
//  clk_i        in   1          system clock
//  rstn_i       in   1          synchronous reset, active-low
//  start_i      in   1          start-load pulse; sampled only in IDLE
//  abort_i      in   1          abandon current load
//  base_addr_i  in   ADDR_W     first word address, latched on start
//  len_i        in   LEN_W      image length in words, latched on start
//  swap_i       in   1          0: first byte -> [7:0]; 1: first byte -> [DATA_W-1:DATA_W-8]; latched on start
//  s_valid_i    in   1          byte stream valid
//  s_data_i     in   8          byte stream data
//  s_ready_o    out  1          byte accepted when s_valid_i & s_ready_o
//  mem_we_o     out  1          write request, held until mem_ack_i
//  mem_addr_o   out  ADDR_W     write word address
//  mem_wdata_o  out  DATA_W     write data
//  mem_ack_i    in   1          write accepted this cycle
//  busy_o       out  1          load in progress
//  done_o       out  1          one-cycle pulse on successful completion
//  err_o        out  1          sticky until next accepted start: range error or abort
//  word_cnt_o   out  LEN_W      words written in current/last load
// BEHAVIOUR
//  - Reset: state IDLE; every output 0; internal byte index, word count, address cleared.
//  - FSM IDLE -> FILL -> WRITE -> (FILL | DONE) -> IDLE; also IDLE -> DONE, IDLE -> ERR -> IDLE.
//  - IDLE: start_i latches base/len/swap, clears err_o and word_cnt_o.
//    len_i==0 -> DONE. base_addr_i+len_i > 2**ADDR_W -> ERR. Otherwise -> FILL.
//  - FILL: s_ready_o=1. Each handshake places byte k into lane k (swap_i=0) or lane BYTES-1-k (swap_i=1).
//    The cycle the BYTES-th byte is accepted -> WRITE (s_ready_o=0 from the next cycle).
//  - WRITE: mem_we_o=1; addr/wdata stable until mem_ack_i. On ack: addr+1, word_cnt+1.
//    Next state: DONE if word_cnt+1==len, else FILL. Ack in the first WRITE cycle is legal (1-cycle write).
//  - DONE: done_o=1 for exactly one cycle, busy_o=0 -> IDLE. ERR: err_o set -> IDLE.
//  - busy_o=1 in FILL and WRITE only. start_i outside IDLE is ignored.
//  - abort_i in FILL/WRITE: -> ERR next cycle. Partial word is discarded. A pending write is dropped
//    unless acked in the same cycle, which counts. abort_i has priority over all stream/ack events.
//  - Address never wraps; the range check guarantees this. word_cnt_o holds after DONE/ERR.
//  - Throughput: BYTES+1 cycles per word with zero-wait memory and a continuous stream.
// CONFIGURATION
//  TCM_LOADER_CRC_EN defined: adds ports crc_o[31:0] and crc_ok_o.
//    CRC-32 (poly 0x04C11DB7, reflected, init 0xFFFFFFFF, xorout 0xFFFFFFFF) over every accepted byte.
//    After the last data word the loader consumes 4 further bytes (little-endian expected CRC).
//    Mismatch -> ERR instead of DONE; match -> crc_ok_o=1 with done_o. Both are cleared on start.
//  Undefined: no CRC ports and no trailer bytes; DONE follows the last write directly.
// STRUCTURE
//  Package tcm_loader_pkg: state enum (IDLE, FILL, WRITE, DONE, ERR[, CRC]); BYTES = DATA_W/8 function;
//    CRC32_POLY / CRC32_INIT constants.
//  Sub-module tcm_loader_crc32: byte-wide CRC update with clear/enable; instantiated only under TCM_LOADER_CRC_EN.
// TESTING
//  1 base=0x10,len=2,swap=0, bytes 11 22 33 44 55 66 77 88 -> [0x10]=0x44332211,[0x11]=0x88776655, one done_o pulse
//  2 same stream, swap=1 -> [0x10]=0x11223344, [0x11]=0x55667788; word_cnt_o=2
//  3 base=0x3FFF,len=2 -> err_o=1 within 2 cycles, no mem_we_o, busy_o never 1
//  4 mem_ack_i delayed 3 cycles per write -> s_ready_o=0 and mem addr/data stable throughout; data correct
//  5 abort_i after 6 bytes of len=4 -> one write only, err_o=1, IDLE; restart with len=1 succeeds and clears err_o
//  6 CRC_EN: 4 data bytes 31 32 33 34 + trailer of their CRC -> crc_ok_o=1; corrupted trailer -> err_o=1, no done_o

Source files
------------

// File: rtl/tcm_loader_pkg.sv
// tcm_loader_pkg: shared types and constants for the TCM image loader.
//   state_t      loader FSM states (CRC only reachable with TCM_LOADER_CRC_EN)
//   bytes_of()   number of byte lanes in a memory word
//   CRC32_*      CRC-32 constants used by the optional trailer check
package tcm_loader_pkg;

   typedef enum logic [2:0] {
      IDLE,
      FILL,
      WRITE,
      DONE,
      ERR,
      CRC
   } state_t;

   localparam logic [31:0] CRC32_POLY   = 32'h04C11DB7;
   localparam logic [31:0] CRC32_INIT   = 32'hFFFFFFFF;
   localparam logic [31:0] CRC32_XOROUT = 32'hFFFFFFFF;

   function automatic int unsigned bytes_of(input int unsigned w);
      return w / 8;
   endfunction

   // Bit-reverse, used to derive the LSB-first polynomial for reflected CRC.
   function automatic logic [31:0] reflect32(input logic [31:0] v);
      logic [31:0] r;
      r = '0;
      for (int unsigned i = 0; i < 32; i++) r[i] = v[31-i];
      return r;
   endfunction

endpackage

// File: rtl/tcm_loader_crc32.sv
// tcm_loader_crc32: byte-wide reflected CRC-32 accumulator.
//   clk, rstn  clock, synchronous active-low reset
//   clr        restart accumulation from CRC32_INIT
//   en         fold data into the running CRC
//   data       byte to fold
//   crc        running CRC with the output XOR applied
module tcm_loader_crc32
   import tcm_loader_pkg::*;
(
   input  logic        clk,
   input  logic        rstn,
   input  logic        clr,
   input  logic        en,
   input  logic [7:0]  data,
   output logic [31:0] crc
);

   localparam logic [31:0] POLY_REFL = reflect32(CRC32_POLY);

   logic [31:0] crc_q;
   logic [31:0] crc_d;

   always_comb begin
      crc_d = crc_q ^ {24'd0, data};
      for (int unsigned i = 0; i < 8; i++)
         crc_d = crc_d[0] ? ((crc_d >> 1) ^ POLY_REFL) : (crc_d >> 1);
   end

   always_ff @(posedge clk) begin
      if (!rstn)    crc_q <= CRC32_INIT;
      else if (clr) crc_q <= CRC32_INIT;
      else if (en)  crc_q <= crc_d;
   end

   assign crc = crc_q ^ CRC32_XOROUT;

endmodule

// File: rtl/tcm_image_loader.sv
// tcm_image_loader: streams a byte image into the TCM as DATA_W words written
// sequentially from a base word address.
//   clk_i/rstn_i          clock, synchronous active-low reset
//   start_i/abort_i       load control (start sampled only in IDLE)
//   base_addr_i/len_i/swap_i  load parameters, latched on start
//   s_valid_i/s_data_i/s_ready_o  byte stream
//   mem_we_o/mem_addr_o/mem_wdata_o/mem_ack_i  TCM write port
//   busy_o/done_o/err_o/word_cnt_o  status
// Optional: TCM_LOADER_CRC_EN adds crc_o/crc_ok_o and a 4-byte CRC-32 trailer.
module tcm_image_loader
   import tcm_loader_pkg::*;
#(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned ADDR_W = 14,
   parameter int unsigned LEN_W  = 15
) (
   input  logic              clk_i,
   input  logic              rstn_i,
   input  logic              start_i,
   input  logic              abort_i,
   input  logic [ADDR_W-1:0] base_addr_i,
   input  logic [LEN_W-1:0]  len_i,
   input  logic              swap_i,
   input  logic              s_valid_i,
   input  logic [7:0]        s_data_i,
   output logic              s_ready_o,
   output logic              mem_we_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [DATA_W-1:0] mem_wdata_o,
   input  logic              mem_ack_i,
   output logic              busy_o,
   output logic              done_o,
   output logic              err_o,
`ifdef TCM_LOADER_CRC_EN
   output logic [31:0]       crc_o,
   output logic              crc_ok_o,
`endif
   output logic [LEN_W-1:0]  word_cnt_o
);

   localparam int unsigned BYTES  = bytes_of(DATA_W);
   localparam int unsigned BIDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;
   localparam int unsigned SUM_W  = ((ADDR_W > LEN_W) ? ADDR_W : LEN_W) + 1;

   state_t              state, nstate;
   logic [ADDR_W-1:0]   addr_q;
   logic [LEN_W-1:0]    len_q, cnt_q;
   logic                swap_q, err_q;
   logic [BIDX_W-1:0]   idx_q, lane;
   logic [DATA_W-1:0]   wbuf_q;
   logic [SUM_W-1:0]    end_addr;
   logic                range_err, last_byte;

   // Wide sum so base+len == 2**ADDR_W (image ends exactly at the top) is legal.
   assign end_addr  = SUM_W'(base_addr_i) + SUM_W'(len_i);
   assign range_err = end_addr > (SUM_W'(1) << ADDR_W);
   assign last_byte = (idx_q == BIDX_W'(BYTES - 1));
   assign lane      = swap_q ? (BIDX_W'(BYTES - 1) - idx_q) : idx_q;

`ifdef TCM_LOADER_CRC_EN
   logic [31:0] crc_val, trl_q;
   logic [1:0]  trl_idx_q;
   logic        crc_ok_q, trl_match;

   // Trailer is little-endian: the newest byte lands in the top lane.
   assign trl_match = ({s_data_i, trl_q[31:8]} == crc_val);

   tcm_loader_crc32 u_crc (
      .clk  (clk_i),
      .rstn (rstn_i),
      .clr  (state == IDLE && start_i),
      .en   (state == FILL && s_valid_i && !abort_i),
      .data (s_data_i),
      .crc  (crc_val)
   );

   assign crc_o    = crc_val;
   assign crc_ok_o = crc_ok_q;
`endif

   always_ff @(posedge clk_i) begin
      if (!rstn_i) state <= IDLE;
      else         state <= nstate;
   end

   always_comb begin
      nstate    = state;
      s_ready_o = 1'b0;
      mem_we_o  = 1'b0;
      busy_o    = 1'b0;
      done_o    = 1'b0;
      case (state)
         IDLE: begin
            if (start_i) begin
               if (len_i == '0)    nstate = DONE;
               else if (range_err) nstate = ERR;
               else                nstate = FILL;
            end
         end
         FILL: begin
            s_ready_o = 1'b1;
            busy_o    = 1'b1;
            if (abort_i)                     nstate = ERR;
            else if (s_valid_i && last_byte) nstate = WRITE;
         end
         WRITE: begin
            mem_we_o = 1'b1;
            busy_o   = 1'b1;
            if (abort_i) nstate = ERR;
            else if (mem_ack_i) begin
`ifdef TCM_LOADER_CRC_EN
               nstate = (cnt_q + LEN_W'(1) == len_q) ? CRC : FILL;
`else
               nstate = (cnt_q + LEN_W'(1) == len_q) ? DONE : FILL;
`endif
            end
         end
`ifdef TCM_LOADER_CRC_EN
         CRC: begin
            s_ready_o = 1'b1;
            busy_o    = 1'b1;
            if (abort_i) nstate = ERR;
            else if (s_valid_i && trl_idx_q == 2'd3)
               nstate = trl_match ? DONE : ERR;
         end
`endif
         DONE: begin
            done_o = 1'b1;
            nstate = IDLE;
         end
         ERR:     nstate = IDLE;
         default: nstate = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         addr_q <= '0;
         len_q  <= '0;
         cnt_q  <= '0;
         swap_q <= 1'b0;
         idx_q  <= '0;
         wbuf_q <= '0;
         err_q  <= 1'b0;
      end else begin
         if (nstate == ERR)                 err_q <= 1'b1;
         else if (state == IDLE && start_i) err_q <= 1'b0;
         case (state)
            IDLE: begin
               if (start_i) begin
                  addr_q <= base_addr_i;
                  len_q  <= len_i;
                  swap_q <= swap_i;
                  cnt_q  <= '0;
                  idx_q  <= '0;
                  wbuf_q <= '0;
               end
            end
            FILL: begin
               if (abort_i) idx_q <= '0;
               else if (s_valid_i) begin
                  for (int unsigned k = 0; k < BYTES; k++)
                     if (lane == BIDX_W'(k)) wbuf_q[k*8 +: 8] <= s_data_i;
                  idx_q <= last_byte ? '0 : idx_q + BIDX_W'(1);
               end
            end
            WRITE: begin
               // An ack coinciding with abort still completes that write.
               if (mem_ack_i) begin
                  addr_q <= addr_q + ADDR_W'(1);
                  cnt_q  <= cnt_q + LEN_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

`ifdef TCM_LOADER_CRC_EN
   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         trl_q     <= '0;
         trl_idx_q <= '0;
         crc_ok_q  <= 1'b0;
      end else if (state == IDLE && start_i) begin
         trl_q     <= '0;
         trl_idx_q <= '0;
         crc_ok_q  <= 1'b0;
      end else if (state == CRC && s_valid_i && !abort_i) begin
         trl_q     <= {s_data_i, trl_q[31:8]};
         trl_idx_q <= trl_idx_q + 2'd1;
         if (trl_idx_q == 2'd3) crc_ok_q <= trl_match;
      end
   end
`endif

   assign mem_addr_o  = addr_q;
   assign mem_wdata_o = wbuf_q;
   assign err_o       = err_q;
   assign word_cnt_o  = cnt_q;

endmodule

// File: tb/tb_tcm_image_loader.sv
// tb_tcm_image_loader: scoreboard bench for tcm_image_loader. Loads are
// described by (base, len, swap, ack delay); a reference model turns the byte
// image into expected (addr, data) writes and a completion event, and a
// negedge monitor compares them as the DUT presents them. Build with
// TCM_LOADER_CRC_EN to exercise the CRC trailer.
module tb_tcm_image_loader;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned ADDR_W = 14;
   localparam int unsigned LEN_W  = 15;
   localparam int unsigned DEPTH  = 1 << ADDR_W;

   logic              clk_i = 1'b0;
   logic              rstn_i = 1'b0;
   logic              start_i = 1'b0;
   logic              abort_i = 1'b0;
   logic [ADDR_W-1:0] base_addr_i = '0;
   logic [LEN_W-1:0]  len_i = '0;
   logic              swap_i = 1'b0;
   logic              s_valid_i = 1'b0;
   logic [7:0]        s_data_i = '0;
   logic              s_ready_o;
   logic              mem_we_o;
   logic [ADDR_W-1:0] mem_addr_o;
   logic [DATA_W-1:0] mem_wdata_o;
   logic              mem_ack_i = 1'b0;
   logic              busy_o, done_o, err_o;
   logic [LEN_W-1:0]  word_cnt_o;
`ifdef TCM_LOADER_CRC_EN
   logic [31:0]       crc_o;
   logic              crc_ok_o;
`endif

   always #5 clk_i = ~clk_i;

   tcm_image_loader #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .LEN_W(LEN_W)) dut (
      .clk_i       (clk_i),
      .rstn_i      (rstn_i),
      .start_i     (start_i),
      .abort_i     (abort_i),
      .base_addr_i (base_addr_i),
      .len_i       (len_i),
      .swap_i      (swap_i),
      .s_valid_i   (s_valid_i),
      .s_data_i    (s_data_i),
      .s_ready_o   (s_ready_o),
      .mem_we_o    (mem_we_o),
      .mem_addr_o  (mem_addr_o),
      .mem_wdata_o (mem_wdata_o),
      .mem_ack_i   (mem_ack_i),
      .busy_o      (busy_o),
      .done_o      (done_o),
      .err_o       (err_o),
`ifdef TCM_LOADER_CRC_EN
      .crc_o       (crc_o),
      .crc_ok_o    (crc_ok_o),
`endif
      .word_cnt_o  (word_cnt_o)
   );

   typedef struct {
      logic [ADDR_W-1:0] a;
      logic [DATA_W-1:0] d;
   } wr_t;

   wr_t         exp_wr[$];
   byte         exp_ev[$];
   logic [7:0]  stim_bytes[$];
   int          checks = 0;
   int          passed = 0;
   int unsigned ack_delay = 0;
   int unsigned we_seen = 0;
   bit          busy_seen = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
   endtask

   // Memory responder and scoreboard monitor.
   bit                in_wr = 0;
   bit                err_prev = 0;
   int unsigned       wait_cnt = 0;
   logic [ADDR_W-1:0] hold_a;
   logic [DATA_W-1:0] hold_d;
   always @(negedge clk_i) begin
      if (!rstn_i) begin
         mem_ack_i = 1'b0;
         in_wr     = 0;
         err_prev  = 0;
      end else begin
         if (busy_o) busy_seen = 1;
         if (done_o) begin
            if (exp_ev.size() == 0) chk("spurious_done", 1, 0);
            else chk("completion_done", 64'd68, 64'(exp_ev.pop_front()));
         end
         if (err_o && !err_prev) begin
            if (exp_ev.size() == 0) chk("spurious_err", 1, 0);
            else chk("completion_err", 64'd69, 64'(exp_ev.pop_front()));
         end
         err_prev = err_o;
         if (mem_we_o) begin
            we_seen++;
            chk("ready_low_in_write", 64'(s_ready_o), 0);
            if (!in_wr) begin
               in_wr    = 1;
               wait_cnt = 0;
               hold_a   = mem_addr_o;
               hold_d   = mem_wdata_o;
            end else begin
               chk("addr_stable", 64'(mem_addr_o), 64'(hold_a));
               chk("data_stable", 64'(mem_wdata_o), 64'(hold_d));
            end
            if (wait_cnt >= ack_delay) begin
               mem_ack_i = 1'b1;
               in_wr     = 0;
               if (exp_wr.size() == 0) chk("unexpected_write", 1, 0);
               else begin
                  wr_t e;
                  e = exp_wr.pop_front();
                  chk("write_addr", 64'(mem_addr_o), 64'(e.a));
                  chk("write_data", 64'(mem_wdata_o), 64'(e.d));
               end
            end else begin
               mem_ack_i = 1'b0;
               wait_cnt++;
            end
         end else begin
            mem_ack_i = 1'b0;
            in_wr     = 0;
         end
      end
   end

   // Called at a negedge; returns at the negedge after the handshake edge.
   task automatic send_byte(input logic [7:0] b);
      bit ok;
      ok = 0;
      repeat ($urandom_range(0, 2)) @(negedge clk_i);
      s_valid_i = 1'b1;
      s_data_i  = b;
      for (int t = 0; t < 200 && !ok; t++) begin
         if (s_ready_o) ok = 1;
         @(negedge clk_i);
      end
      s_valid_i = 1'b0;
      if (!ok) chk("stream_timeout", 1, 0);
   endtask

`ifdef TCM_LOADER_CRC_EN
   function automatic logic [31:0] crc_ref(input int unsigned n);
      logic [31:0] c;
      c = 32'hFFFFFFFF;
      for (int unsigned i = 0; i < n; i++) begin
         c = c ^ {24'd0, stim_bytes[i]};
         for (int j = 0; j < 8; j++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
      end
      return ~c;
   endfunction
`endif

   task automatic issue_start(input int unsigned base, input int unsigned len, input bit swap);
      @(negedge clk_i);
      start_i     = 1'b1;
      base_addr_i = ADDR_W'(base);
      len_i       = LEN_W'(len);
      swap_i      = swap;
      @(negedge clk_i);
      start_i = 1'b0;
   endtask

   task automatic wait_idle();
      bit ok;
      ok = 0;
      for (int t = 0; t < 400 && !ok; t++) begin
         @(negedge clk_i);
         if (exp_ev.size() == 0 && !busy_o) ok = 1;
      end
      if (!ok) chk("load_timeout", 1, 0);
   endtask

   task automatic run_load(input int unsigned base, input int unsigned len, input bit swap,
                           input int unsigned dly, input bit corrupt);
      bit          rng;
      int unsigned exp_cnt;
      ack_delay = dly;
      rng = (base + len) > DEPTH;
      while (stim_bytes.size() < len * 4) stim_bytes.push_back(8'($urandom));
      if (len == 0) begin
         exp_ev.push_back("D");
         exp_cnt = 0;
      end else if (rng) begin
         exp_ev.push_back("E");
         exp_cnt = 0;
      end else begin
         for (int unsigned w = 0; w < len; w++) begin
            wr_t e;
            e.a = ADDR_W'(base + w);
            e.d = '0;
            for (int unsigned k = 0; k < 4; k++)
               e.d = e.d | (DATA_W'(stim_bytes[w*4+k]) << (swap ? (3 - k) * 8 : k * 8));
            exp_wr.push_back(e);
         end
`ifdef TCM_LOADER_CRC_EN
         exp_ev.push_back(corrupt ? "E" : "D");
`else
         exp_ev.push_back("D");
`endif
         exp_cnt = len;
      end
      issue_start(base, len, swap);
      if (len != 0 && rng) chk("range_err_latency", 64'(err_o), 1);
      else                 chk("err_clear_on_start", 64'(err_o), 0);
`ifdef TCM_LOADER_CRC_EN
      chk("crc_ok_clear_on_start", 64'(crc_ok_o), 0);
`endif
      if (len != 0 && !rng) begin
         for (int unsigned i = 0; i < len * 4; i++) send_byte(stim_bytes[i]);
`ifdef TCM_LOADER_CRC_EN
         begin
            logic [31:0] c;
            c = crc_ref(len * 4) ^ (corrupt ? 32'h1 : 32'h0);
            for (int unsigned i = 0; i < 4; i++) send_byte(c[i*8 +: 8]);
         end
`endif
      end
      wait_idle();
      @(negedge clk_i);
      chk("word_cnt", 64'(word_cnt_o), 64'(exp_cnt));
      chk("busy_after_load", 64'(busy_o), 0);
      chk("err_after_load", 64'(err_o), 64'((len != 0 && rng) || corrupt));
`ifdef TCM_LOADER_CRC_EN
      if (len != 0 && !rng) chk("crc_ok", 64'(crc_ok_o), 64'(!corrupt));
`endif
      chk("writes_drained", 64'(exp_wr.size()), 0);
      stim_bytes.delete();
   endtask

   task automatic load_t1_bytes();
      stim_bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
   endtask

   initial begin
      repeat (3) @(negedge clk_i);
      chk("rst_s_ready", 64'(s_ready_o), 0);
      chk("rst_mem_we", 64'(mem_we_o), 0);
      chk("rst_mem_addr", 64'(mem_addr_o), 0);
      chk("rst_mem_wdata", 64'(mem_wdata_o), 0);
      chk("rst_busy", 64'(busy_o), 0);
      chk("rst_done", 64'(done_o), 0);
      chk("rst_err", 64'(err_o), 0);
      chk("rst_word_cnt", 64'(word_cnt_o), 0);
      rstn_i = 1'b1;
      @(negedge clk_i);

      load_t1_bytes();
      run_load(32'h10, 2, 1'b0, 0, 1'b0);
      load_t1_bytes();
      run_load(32'h10, 2, 1'b1, 0, 1'b0);

      busy_seen = 0;
      we_seen   = 0;
      run_load(32'h3FFF, 2, 1'b0, 0, 1'b0);
      chk("range_no_busy", 64'(busy_seen), 0);
      chk("range_no_write", 64'(we_seen), 0);

      run_load(32'h40, 3, 1'b0, 3, 1'b0);
      run_load(32'h3FFE, 2, 1'b1, 1, 1'b0);
      run_load(32'h3FFF, 1, 1'b0, 0, 1'b0);
      run_load(32'h20, 0, 1'b0, 0, 1'b0);

      // Abort mid-word on a 4-word load: only the first word reaches memory.
      begin
         wr_t e;
         ack_delay = 0;
         for (int i = 0; i < 6; i++) stim_bytes.push_back(8'($urandom));
         e.a = ADDR_W'(32'h100);
         e.d = {stim_bytes[3], stim_bytes[2], stim_bytes[1], stim_bytes[0]};
         exp_wr.push_back(e);
         exp_ev.push_back("E");
         issue_start(32'h100, 4, 1'b0);
         for (int i = 0; i < 6; i++) send_byte(stim_bytes[i]);
         abort_i = 1'b1;
         @(negedge clk_i);
         abort_i = 1'b0;
         wait_idle();
         @(negedge clk_i);
         chk("abort_word_cnt", 64'(word_cnt_o), 1);
         chk("abort_err", 64'(err_o), 1);
         chk("abort_idle_ready", 64'(s_ready_o), 0);
         chk("abort_writes_drained", 64'(exp_wr.size()), 0);
         stim_bytes.delete();
      end
      run_load(32'h200, 1, 1'b0, 0, 1'b0);

`ifdef TCM_LOADER_CRC_EN
      stim_bytes = '{8'h31, 8'h32, 8'h33, 8'h34};
      run_load(32'h300, 1, 1'b0, 0, 1'b0);
      stim_bytes = '{8'h31, 8'h32, 8'h33, 8'h34};
      run_load(32'h300, 1, 1'b0, 0, 1'b1);
`endif

      for (int n = 0; n < 10; n++) begin
         int unsigned b, l;
         b = $urandom_range(0, DEPTH - 1);
         l = $urandom_range(0, 4);
         if ($urandom_range(0, 3) == 0) b = DEPTH - $urandom_range(1, 4);
         run_load(b, l, 1'($urandom), $urandom_range(0, 2), 1'b0);
      end

      chk("events_drained", 64'(exp_ev.size()), 0);
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
